// File: rtl/airlock_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : airlock_controller_pkg
// Brief    : Shared state encoding and request bundle for the airlock block.
// Revision : 1.0 - initial release
// ============================================================================
package airlock_controller_pkg;

  // 3-bit state encoding, also the value shown on the StateCode/HEX output
  localparam int C_STATE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    ST_EVACUATED    = 3'd0,
    ST_INNER_OPEN   = 3'd1,
    ST_PRESSURIZING = 3'd2,
    ST_PRESSURIZED  = 3'd3,
    ST_OUTER_OPEN   = 3'd4,
    ST_EVACUATING   = 3'd5
  } state_t;

  // True for the two timed phases
  function automatic logic is_phase(input state_t st);
    return (st == ST_PRESSURIZING) || (st == ST_EVACUATING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/airlock_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : airlock_controller_if
// Brief    : Request pulses in, door/phase status out for the airlock block.
// Revision : 1.0 - initial release
// ============================================================================
interface airlock_controller_if #(
  parameter int CNT_W = 8
);
  logic             outer_req;
  logic             inner_req;
  logic             press_req;
  logic             evac_req;
  logic             outer_open;
  logic             inner_open;
  logic             pressurized;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             reject;
  logic [2:0]       state_code;

  modport master (
    output outer_req, inner_req, press_req, evac_req,
    input  outer_open, inner_open, pressurized, busy, remaining, reject, state_code
  );

  modport slave (
    input  outer_req, inner_req, press_req, evac_req,
    output outer_open, inner_open, pressurized, busy, remaining, reject, state_code
  );
endinterface
`default_nettype wire

// File: rtl/airlock_timer.sv
`default_nettype none
// ============================================================================
// Module   : airlock_timer
// Brief    : Loadable down-counter that stops at zero; times both phases.
// Revision : 1.0 - initial release
// ============================================================================
module airlock_timer #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  output logic      [CNT_W-1:0] o_remaining,
  output logic                  o_done
);

  logic [CNT_W-1:0] r_remaining;

  // Load wins over counting; the decrement is gated at zero so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (i_load) begin
      r_remaining <= i_load_val;
    end else if (r_remaining != '0) begin
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  assign o_remaining = r_remaining;
  assign o_done      = (r_remaining == '0) && !i_load;

endmodule
`default_nettype wire

// File: rtl/airlock_controller.sv
`default_nettype none
// ============================================================================
// Module   : airlock_controller
// Brief    : Airlock sequencer with door interlock and timed fill/evacuate
//            phases. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module airlock_controller
  import airlock_controller_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int PRESS_CYCLES = 5,
  parameter int EVAC_CYCLES  = 7
) (
  input wire logic          clk,
  input wire logic          rst,
  airlock_controller_if.slave bus
);

  localparam int C_CNT_MAX = (2 ** CNT_W) - 1;

  // Elaboration-time parameter range checks
  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("airlock_controller: CNT_W must be 1..30");
  end
  if (PRESS_CYCLES < 1 || PRESS_CYCLES > C_CNT_MAX) begin : g_bad_press_cycles
    $error("airlock_controller: PRESS_CYCLES must be 1..2**CNT_W-1");
  end
  if (EVAC_CYCLES < 1 || EVAC_CYCLES > C_CNT_MAX) begin : g_bad_evac_cycles
    $error("airlock_controller: EVAC_CYCLES must be 1..2**CNT_W-1");
  end

  // Timer holds N-1 on entry so that the phase lasts exactly N clocks
  localparam logic [CNT_W-1:0] C_PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_reject;
  logic             w_any_req;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;
  logic [CNT_W-1:0] w_remaining;

  logic             r_outer_open;
  logic             r_inner_open;
  logic             r_pressurized;
  logic             r_busy;
  logic             r_reject;

  assign w_any_req = bus.evac_req | bus.press_req | bus.inner_req | bus.outer_req;

  // Phase start/abort: decided from state and requests only, so it never depends on w_done
  always_comb begin
    w_load     = 1'b0;
    w_load_val = C_PRESS_LOAD;
    case (r_state)
      ST_EVACUATED, ST_EVACUATING: begin
        if (bus.press_req) begin
          w_load     = 1'b1;
          w_load_val = C_PRESS_LOAD;
        end
      end
      ST_PRESSURIZING, ST_PRESSURIZED: begin
        if (bus.evac_req) begin
          w_load     = 1'b1;
          w_load_val = C_EVAC_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Next state: highest-priority legal request wins, Reject only if none is legal
  always_comb begin
    w_next   = r_state;
    w_reject = 1'b0;
    case (r_state)
      ST_EVACUATED: begin
        if (w_load)             w_next = ST_PRESSURIZING;
        else if (bus.inner_req) w_next = ST_INNER_OPEN;
        else                    w_reject = w_any_req;
      end
      ST_INNER_OPEN: begin
        if (bus.inner_req) w_next = ST_EVACUATED;
        else               w_reject = w_any_req;
      end
      ST_PRESSURIZING: begin
        if (w_load) begin
          w_next = ST_EVACUATING;
        end else begin
          w_reject = w_any_req;
          if (w_done) w_next = ST_PRESSURIZED;
        end
      end
      ST_PRESSURIZED: begin
        if (w_load)             w_next = ST_EVACUATING;
        else if (bus.outer_req) w_next = ST_OUTER_OPEN;
        else                    w_reject = w_any_req;
      end
      ST_OUTER_OPEN: begin
        if (bus.outer_req) w_next = ST_PRESSURIZED;
        else               w_reject = w_any_req;
      end
      ST_EVACUATING: begin
        if (w_load) begin
          w_next = ST_PRESSURIZING;
        end else begin
          w_reject = w_any_req;
          if (w_done) w_next = ST_EVACUATED;
        end
      end
      default: w_next = ST_EVACUATED;
    endcase
  end

  // State register with outputs decoded from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_EVACUATED;
      r_outer_open  <= 1'b0;
      r_inner_open  <= 1'b0;
      r_pressurized <= 1'b0;
      r_busy        <= 1'b0;
      r_reject      <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_outer_open  <= (w_next == ST_OUTER_OPEN);
      r_inner_open  <= (w_next == ST_INNER_OPEN);
      r_pressurized <= (w_next == ST_PRESSURIZED) || (w_next == ST_OUTER_OPEN);
      r_busy        <= is_phase(w_next);
      r_reject      <= w_reject;
    end
  end

  airlock_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_remaining (w_remaining),
    .o_done      (w_done)
  );

  assign bus.outer_open  = r_outer_open;
  assign bus.inner_open  = r_inner_open;
  assign bus.pressurized = r_pressurized;
  assign bus.busy        = r_busy;
  assign bus.remaining   = w_remaining;
  assign bus.reject      = r_reject;
  assign bus.state_code  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_airlock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_airlock_controller
// Brief    : Directed self-checking bench for airlock_controller
//            (CNT_W=8, PRESS_CYCLES=5, EVAC_CYCLES=7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_airlock_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_v;
  logic [15:0] obs_v;

  airlock_controller_if #(.CNT_W(8)) bus ();

  airlock_controller #(
    .CNT_W        (8),
    .PRESS_CYCLES (5),
    .EVAC_CYCLES  (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed view: {outer_open, inner_open, pressurized, busy, reject, state_code[2:0], remaining[7:0]}
  function automatic logic [15:0] mk(input logic oo, input logic io, input logic pz,
                                     input logic bz, input logic rj,
                                     input logic [2:0] sc, input logic [7:0] rem);
    return {oo, io, pz, bz, rj, sc, rem};
  endfunction

  function automatic logic [15:0] status();
    return {bus.outer_open, bus.inner_open, bus.pressurized, bus.busy,
            bus.reject, bus.state_code, bus.remaining};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold requests across exactly one rising edge, then sample the cycle after it
  task automatic do_req(input logic e, input logic p, input logic i, input logic o);
    bus.evac_req  = e;
    bus.press_req = p;
    bus.inner_req = i;
    bus.outer_req = o;
    tick();
    bus.evac_req  = 1'b0;
    bus.press_req = 1'b0;
    bus.inner_req = 1'b0;
    bus.outer_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL reset: got %h want %h", obs_v, exp_v); end
    @(negedge clk) rst = 1'b0;
    tick();
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL reset_idle: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_pressurize();
    do_req(0,1,0,0);
    for (int k = 4; k >= 0; k--) begin
      exp_v = mk(0,0,0,1,0,3'd2,8'(k)); obs_v = status(); tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL press_count k=%0d: got %h want %h", k, obs_v, exp_v); end
      tick();
    end
    exp_v = mk(0,0,1,0,0,3'd3,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL press_done: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_pressurized_ports();
    do_req(0,0,1,0);
    exp_v = mk(0,0,1,0,1,3'd3,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL pz_inner_reject: got %h want %h", obs_v, exp_v); end
    tick();
    exp_v = mk(0,0,1,0,0,3'd3,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL pz_reject_one_cycle: got %h want %h", obs_v, exp_v); end
    do_req(0,0,0,1);
    exp_v = mk(1,0,1,0,0,3'd4,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL outer_open: got %h want %h", obs_v, exp_v); end
    do_req(0,0,1,0);
    exp_v = mk(1,0,1,0,1,3'd4,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL outer_inner_reject: got %h want %h", obs_v, exp_v); end
    do_req(0,0,0,1);
    exp_v = mk(0,0,1,0,0,3'd3,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL outer_close: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_evacuate();
    do_req(1,0,0,0);
    for (int k = 6; k >= 0; k--) begin
      exp_v = mk(0,0,0,1,0,3'd5,8'(k)); obs_v = status(); tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL evac_count k=%0d: got %h want %h", k, obs_v, exp_v); end
      tick();
    end
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL evac_done: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_evacuated_rules();
    do_req(0,0,0,1);
    exp_v = mk(0,0,0,0,1,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL ev_outer_reject: got %h want %h", obs_v, exp_v); end
    tick();
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL ev_reject_one_cycle: got %h want %h", obs_v, exp_v); end
    do_req(0,0,1,0);
    exp_v = mk(0,1,0,0,0,3'd1,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL inner_open: got %h want %h", obs_v, exp_v); end
    do_req(0,1,0,0);
    exp_v = mk(0,1,0,0,1,3'd1,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL inner_press_reject: got %h want %h", obs_v, exp_v); end
    do_req(0,0,1,0);
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL inner_close: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_abort();
    do_req(0,1,0,0);
    tick();
    tick();
    exp_v = mk(0,0,0,1,0,3'd2,8'd2); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL abort_pre: got %h want %h", obs_v, exp_v); end
    do_req(1,0,0,0);
    for (int k = 6; k >= 0; k--) begin
      exp_v = mk(0,0,0,1,0,3'd5,8'(k)); obs_v = status(); tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL abort_evac k=%0d: got %h want %h", k, obs_v, exp_v); end
      tick();
    end
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL abort_done: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_simultaneous();
    do_req(0,1,1,0);
    exp_v = mk(0,0,0,1,0,3'd2,8'd4); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_press_inner: got %h want %h", obs_v, exp_v); end
    do_req(1,1,0,0);
    exp_v = mk(0,0,0,1,0,3'd5,8'd6); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_evac_over_press: got %h want %h", obs_v, exp_v); end
    do_req(0,1,1,1);
    exp_v = mk(0,0,0,1,0,3'd2,8'd4); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_evac_abort: got %h want %h", obs_v, exp_v); end
    repeat (5) tick();
    exp_v = mk(0,0,1,0,0,3'd3,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_pressurized: got %h want %h", obs_v, exp_v); end
    do_req(0,0,1,1);
    exp_v = mk(1,0,1,0,0,3'd4,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_outer_over_inner: got %h want %h", obs_v, exp_v); end
    do_req(1,1,1,1);
    exp_v = mk(0,0,1,0,0,3'd3,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_all_in_outer_open: got %h want %h", obs_v, exp_v); end
    do_req(1,0,0,0);
    repeat (7) tick();
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL sim_final_evacuated: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_async_reset();
    do_req(0,1,0,0);
    do_req(1,0,0,0);
    tick();
    exp_v = mk(0,0,0,1,0,3'd5,8'd5); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL arst_pre: got %h want %h", obs_v, exp_v); end
    #2 rst = 1'b1;
    #1;
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL arst_immediate: got %h want %h", obs_v, exp_v); end
    @(negedge clk) rst = 1'b0;
    tick();
    exp_v = mk(0,0,0,0,0,3'd0,8'd0); obs_v = status(); tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL arst_after: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_random();
    logic [4:0] bad;
    for (int c = 0; c < 10000; c++) begin
      bus.evac_req  = ($urandom_range(0, 5) == 0);
      bus.press_req = ($urandom_range(0, 4) == 0);
      bus.inner_req = ($urandom_range(0, 3) == 0);
      bus.outer_req = ($urandom_range(0, 3) == 0);
      tick();
      bad = {bus.outer_open & bus.inner_open,
             bus.outer_open & bus.busy,
             bus.inner_open & bus.busy,
             !bus.busy && (bus.remaining != 8'd0),
             bus.state_code > 3'd5};
      tests++;
      if (bad !== 5'b0) begin
        fails++;
        $display("FAIL invariant cycle=%0d: got %b want 00000", c, bad);
      end
    end
    bus.evac_req  = 1'b0;
    bus.press_req = 1'b0;
    bus.inner_req = 1'b0;
    bus.outer_req = 1'b0;
  endtask

  initial begin
    bus.evac_req  = 1'b0;
    bus.press_req = 1'b0;
    bus.inner_req = 1'b0;
    bus.outer_req = 1'b0;
    test_reset();
    test_pressurize();
    test_pressurized_ports();
    test_evacuate();
    test_evacuated_rules();
    test_abort();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
